// File: rtl/mem_arb.sv
// Single-port memory arbiter: shares one memory port between instruction fetch
// and data load/store, data first, with a fetch starvation guard and an access timeout.
module mem_arb #(
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic        clk,
  input  logic        rst_f,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  output logic        if_ack,
  output logic        if_err,
  output logic [31:0] if_rdata,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [15:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic        dm_ack,
  output logic        dm_err,
  output logic [31:0] dm_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY_IF = 2'd1, BUSY_DM = 2'd2} state_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
  localparam logic [7:0] TMO_LAST   = 8'(TIMEOUT - 1);

  state_t      state_r, state_s;
  logic [3:0]  streak_r, streak_s;
  logic [7:0]  tmo_r, tmo_s;
  logic        if_pend_s, dm_pend_s, is_dm_s;
  logic        if_ack_s, if_err_s, dm_ack_s, dm_err_s;
  logic [31:0] if_rdata_s, dm_rdata_s;
  logic        mem_req_s, mem_we_s, busy_s;
  logic [15:0] mem_addr_s;
  logic [31:0] mem_wdata_s;

  // A requester being acked this cycle is still holding req and must not be re-granted.
  assign if_pend_s = if_req & ~if_ack;
  assign dm_pend_s = dm_req & ~dm_ack;
  assign is_dm_s   = (state_r == BUSY_DM);

  // Next-state, arbitration and registered-output next values.
  always_comb begin
    state_s     = state_r;
    streak_s    = streak_r;
    tmo_s       = tmo_r;
    if_ack_s    = 1'b0;
    if_err_s    = 1'b0;
    dm_ack_s    = 1'b0;
    dm_err_s    = 1'b0;
    if_rdata_s  = if_rdata;
    dm_rdata_s  = dm_rdata;
    mem_req_s   = mem_req;
    mem_we_s    = mem_we;
    mem_addr_s  = mem_addr;
    mem_wdata_s = mem_wdata;
    case (state_r)
      IDLE: begin
        if (dm_pend_s && (!if_pend_s || (streak_r < STARVE_LIM))) begin
          state_s     = BUSY_DM;
          mem_req_s   = 1'b1;
          mem_we_s    = dm_we;
          mem_addr_s  = dm_addr;
          mem_wdata_s = dm_wdata;
          tmo_s       = 8'd0;
          if (if_req) begin
            streak_s = (streak_r < STARVE_LIM) ? (streak_r + 4'd1) : streak_r;
          end else begin
            streak_s = 4'd0;
          end
        end else if (if_pend_s) begin
          state_s     = BUSY_IF;
          mem_req_s   = 1'b1;
          mem_we_s    = 1'b0;
          mem_addr_s  = if_addr;
          mem_wdata_s = 32'h0;
          tmo_s       = 8'd0;
          streak_s    = 4'd0;
        end else begin
          state_s = IDLE;
        end
      end
      BUSY_IF, BUSY_DM: begin
        // A late mem_ack coinciding with the timeout still completes normally.
        if (mem_ack || (tmo_r == TMO_LAST)) begin
          state_s     = IDLE;
          mem_req_s   = 1'b0;
          mem_we_s    = 1'b0;
          mem_wdata_s = 32'h0;
          if (is_dm_s) begin
            dm_ack_s   = 1'b1;
            dm_err_s   = ~mem_ack;
            dm_rdata_s = mem_ack ? mem_rdata : 32'h0;
          end else begin
            if_ack_s   = 1'b1;
            if_err_s   = ~mem_ack;
            if_rdata_s = mem_ack ? mem_rdata : 32'h0;
          end
        end else begin
          tmo_s = tmo_r + 8'd1;
        end
      end
      default: begin
        state_s     = IDLE;
        mem_req_s   = 1'b0;
        mem_we_s    = 1'b0;
        mem_wdata_s = 32'h0;
      end
    endcase
    busy_s = (state_s != IDLE);
  end

  // State and output registers; reset abandons any access without an ack.
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      state_r   <= IDLE;
      streak_r  <= 4'd0;
      tmo_r     <= 8'd0;
      if_ack    <= 1'b0;
      if_err    <= 1'b0;
      if_rdata  <= 32'h0;
      dm_ack    <= 1'b0;
      dm_err    <= 1'b0;
      dm_rdata  <= 32'h0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 16'h0;
      mem_wdata <= 32'h0;
      busy      <= 1'b0;
    end else begin
      state_r   <= state_s;
      streak_r  <= streak_s;
      tmo_r     <= tmo_s;
      if_ack    <= if_ack_s;
      if_err    <= if_err_s;
      if_rdata  <= if_rdata_s;
      dm_ack    <= dm_ack_s;
      dm_err    <= dm_err_s;
      dm_rdata  <= dm_rdata_s;
      mem_req   <= mem_req_s;
      mem_we    <= mem_we_s;
      mem_addr  <= mem_addr_s;
      mem_wdata <= mem_wdata_s;
      busy      <= busy_s;
    end
  end

endmodule
